// File: rtl/echo_ctrl.sv
// Echo delay-line sequencer: debounced on/off toggle, delay-line flush on enable,
// and a 0..16 gain ramp that fades the wet tap in and out of the dry sample stream.
module echo_ctrl #(
  parameter int RESOLUTION      = 32,
  parameter int DEPTH           = 128,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  button_i,
  input  logic                  sample_valid_i,
  input  logic [RESOLUTION-1:0] data_in_i,
  input  logic [RESOLUTION-1:0] tap_in_i,
  output logic                  shift_en_o,
  output logic [RESOLUTION-1:0] line_data_o,
  output logic [RESOLUTION-1:0] data_out_o,
  output logic                  out_valid_o,
  output logic                  echo_on_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    BYPASS    = 3'd0,
    FLUSH     = 3'd1,
    RAMP_UP   = 3'd2,
    ECHO      = 3'd3,
    RAMP_DOWN = 3'd4
  } state_e;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = 2 * RESOLUTION;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DEPTH - 1);
  localparam logic [4:0]    GAIN_MAX   = 5'd16;

  state_e                  state_q, state_d;
  logic [4:0]              gain_q, gain_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic                    sync1_q, sync2_q;
  logic                    deb_level_q, deb_level_d;
  logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
  logic                    press_s;
  logic [RESOLUTION-1:0]   data_out_q;
  logic                    out_valid_q;
  logic [RESOLUTION-1:0]   wet_s;
  logic [RESOLUTION-1:0]   mix_s;

  // Button synchronizer and debouncer state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      sync1_q     <= button_i;
      sync2_q     <= sync1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle; press fires that same cycle.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = sync2_q;
        deb_cnt_d   = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
    press_s = deb_level_d & ~deb_level_q;
  end

  // FSM state, gain and flush counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= BYPASS;
      gain_q      <= 5'd0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state; a press overrides the ramp-complete transition but not the gain step.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      BYPASS: begin
        gain_d      = 5'd0;
        flush_cnt_d = '0;
        if (press_s) state_d = FLUSH;
        else         state_d = BYPASS;
      end
      FLUSH: begin
        gain_d = 5'd0;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = RAMP_UP;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      RAMP_UP: begin
        if (sample_valid_i && (gain_q != GAIN_MAX)) gain_d = gain_q + 5'd1;
        else                                        gain_d = gain_q;
        if (press_s)                   state_d = RAMP_DOWN;
        else if (gain_d == GAIN_MAX)   state_d = ECHO;
        else                           state_d = RAMP_UP;
      end
      ECHO: begin
        gain_d = GAIN_MAX;
        if (press_s) state_d = RAMP_DOWN;
        else         state_d = ECHO;
      end
      RAMP_DOWN: begin
        if (sample_valid_i && (gain_q != 5'd0)) gain_d = gain_q - 5'd1;
        else                                    gain_d = gain_q;
        if (press_s)                                 state_d = RAMP_UP;
        else if (sample_valid_i && (gain_d == 5'd0)) state_d = BYPASS;
        else                                         state_d = RAMP_DOWN;
      end
      default: begin
        state_d     = BYPASS;
        gain_d      = 5'd0;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Delay-line control and status decoded from the current state.
  always_comb begin
    shift_en_o  = 1'b0;
    line_data_o = '0;
    echo_on_o   = 1'b0;
    case (state_q)
      FLUSH: begin
        shift_en_o  = 1'b1;
        line_data_o = '0;
        echo_on_o   = 1'b0;
      end
      RAMP_UP, ECHO, RAMP_DOWN: begin
        shift_en_o  = sample_valid_i;
        line_data_o = data_in_i;
        echo_on_o   = 1'b1;
      end
      default: begin
        shift_en_o  = 1'b0;
        line_data_o = '0;
        echo_on_o   = 1'b0;
      end
    endcase
  end

  // Wet path uses the pre-update gain; gain is 0 in BYPASS/FLUSH so those samples pass dry.
  always_comb begin
    wet_s = RESOLUTION'((PW'(tap_in_i) * PW'(gain_q)) >> 4);
    mix_s = data_in_i + wet_s;
  end

  // Registered mixer output and its strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= sample_valid_i;
      if (sample_valid_i) data_out_q <= mix_s;
      else                data_out_q <= data_out_q;
    end
  end

  assign data_out_o  = data_out_q;
  assign out_valid_o = out_valid_q;
  assign state_o     = state_q;

endmodule
